// File: rtl/dither_packer_if.sv
// Bus bundle between the dither stage, the packer and the frame-buffer writer.
// slave = packer side (pixels in, words out); master = the other end.
interface dither_packer_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 13
);
  logic              dithered_pixel;
  logic [10:0]       dithered_hcount;
  logic [9:0]        dithered_vcount;
  logic              dithered_valid;
  logic [WORD_W-1:0] word_data;
  logic [ADDR_W-1:0] word_addr;
  logic              word_valid;
  logic              word_ready;
  logic              frame_done;
  logic              overflow;

  modport slave (
    input  dithered_pixel, dithered_hcount, dithered_vcount, dithered_valid, word_ready,
    output word_data, word_addr, word_valid, frame_done, overflow
  );

  modport master (
    output dithered_pixel, dithered_hcount, dithered_vcount, dithered_valid, word_ready,
    input  word_data, word_addr, word_valid, frame_done, overflow
  );
endinterface

// File: rtl/dither_packer.sv
// Packs the 1-bit dithered pixel stream into WORD_W-bit frame-buffer words with
// addresses, buffered through a small FIFO so back-pressure never reaches the dither stage.
module dither_packer #(
  parameter int WORD_W     = 16,
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk_in,
  input logic            rst_n_in,
  dither_packer_if.slave bus
);
  localparam int          SH     = $clog2(WORD_W);
  localparam int          WPR    = (H_ACTIVE + WORD_W - 1) / WORD_W;
  localparam int          PW     = $clog2(FIFO_DEPTH);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

  logic [WORD_W-1:0] r_asm;
  logic [WORD_W-1:0] r_dat [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_adr [FIFO_DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [PW:0]       r_cnt;
  logic              r_fd, r_ovf;

  logic              w_acc, w_commit, w_last_px, w_full, w_pop, w_push, w_drop;
  logic [SH-1:0]     w_bit;
  logic [WORD_W-1:0] w_word;
  logic [ADDR_W-1:0] w_addr;

  assign w_acc     = bus.dithered_valid && (bus.dithered_hcount <= H_LAST) &&
                     (bus.dithered_vcount <= V_LAST);
  assign w_bit     = bus.dithered_hcount[SH-1:0];
  assign w_commit  = w_acc && ((&w_bit) || (bus.dithered_hcount == H_LAST));
  assign w_last_px = w_acc && (bus.dithered_hcount == H_LAST) && (bus.dithered_vcount == V_LAST);
  assign w_addr    = ADDR_W'(bus.dithered_vcount) * ADDR_W'(WPR) +
                     ADDR_W'(bus.dithered_hcount >> SH);

  // The committing pixel must land in the pushed word, so merge it combinationally.
  always_comb begin
    w_word        = r_asm;
    w_word[w_bit] = bus.dithered_pixel;
  end

  assign w_full = (r_cnt == (PW+1)'(FIFO_DEPTH));
  assign w_pop  = (r_cnt != '0) && bus.word_ready;
  assign w_push = w_commit && (!w_full || w_pop);
  assign w_drop = w_commit && w_full && !w_pop;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_asm <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_fd  <= 1'b0;
      r_ovf <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_dat[i] <= '0;
        r_adr[i] <= '0;
      end
    end else begin
      if (w_commit)   r_asm <= '0;
      else if (w_acc) r_asm <= w_word;
      if (w_push) begin
        r_dat[r_wp] <= w_word;
        r_adr[r_wp] <= w_addr;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_drop) r_ovf <= 1'b1;
      r_fd <= w_last_px;
    end
  end

  assign bus.word_data  = r_dat[r_rp];
  assign bus.word_addr  = r_adr[r_rp];
  assign bus.word_valid = (r_cnt != '0);
  assign bus.frame_done = r_fd;
  assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_dither_packer.sv
// Scoreboard bench for dither_packer: a 320-wide instance for most scenarios and a
// 328-wide instance for the zero-padded row-end flush.
module tb_dither_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_cyc = 1'b0;

  typedef struct {logic [15:0] d; logic [12:0] a; int c;} ent_t;
  ent_t exp_q[$];
  ent_t obs_q[$];
  ent_t obs2_q[$];
  logic [15:0] m_asm = '0;

  dither_packer_if #(.WORD_W(16), .ADDR_W(13)) bus ();
  dither_packer_if #(.WORD_W(16), .ADDR_W(13)) bus2 ();

  dither_packer #(.WORD_W(16), .H_ACTIVE(320), .V_ACTIVE(240), .ADDR_W(13), .FIFO_DEPTH(4))
    dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));
  dither_packer #(.WORD_W(16), .H_ACTIVE(328), .V_ACTIVE(240), .ADDR_W(13), .FIFO_DEPTH(4))
    dut2 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus2));

  // Capture every word the consumer actually takes.
  always @(negedge clk) begin
    if (rst_n && bus.word_valid && bus.word_ready)
      obs_q.push_back('{d: bus.word_data, a: bus.word_addr, c: cyc});
    if (rst_n && bus2.word_valid && bus2.word_ready)
      obs2_q.push_back('{d: bus2.word_data, a: bus2.word_addr, c: cyc});
  end

  task automatic px(input logic p, input int h, input int v, input logic vld = 1'b1);
    @(posedge clk); #1;
    bus.dithered_pixel  = p;
    bus.dithered_hcount = 11'(h);
    bus.dithered_vcount = 10'(v);
    bus.dithered_valid  = vld;
    if (vld && h < 320 && v < 240) begin
      m_asm[4'(h % 16)] = p;
      if (h % 16 == 15 || h == 319) begin
        exp_q.push_back('{d: m_asm, a: 13'(v * 20 + h / 16), c: chk_cyc ? cyc + 1 : -1});
        m_asm = '0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.dithered_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.dithered_valid = 1'b0;
    bus2.dithered_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete(); obs_q.delete(); obs2_q.delete();
    m_asm = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.word_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.word_valid); end
    n_cmp++; if (bus.word_data !== 16'h0) begin n_err++; $display("FAIL reset_data got %h want 0000", bus.word_data); end
    n_cmp++; if (bus.word_addr !== 13'h0) begin n_err++; $display("FAIL reset_addr got %0d want 0", bus.word_addr); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
    n_cmp++; if (bus2.word_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid2 got %b want 0", bus2.word_valid); end
  endtask

  task automatic test_row_pattern();
    ent_t o, e;
    bus.word_ready = 1'b1;
    chk_cyc = 1'b1;
    for (int h = 0; h < 320; h++) px(1'(h), h, 0);
    idle(3);
    chk_cyc = 1'b0;
    n_cmp++; if (obs_q.size() != 20) begin n_err++; $display("FAIL row_count got %0d want 20", obs_q.size()); end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o.d !== 16'hAAAA || o.a !== 13'(i) || o.c != e.c) begin
        n_err++;
        $display("FAIL row_word%0d got %h@%0d cyc %0d want aaaa@%0d cyc %0d", i, o.d, o.a, o.c, i, e.c);
      end
    end
  endtask

  task automatic test_row_flush();
    bus2.word_ready = 1'b1;
    for (int h = 0; h < 328; h++) begin
      @(posedge clk); #1;
      bus2.dithered_pixel = 1'b1; bus2.dithered_hcount = 11'(h);
      bus2.dithered_vcount = 10'd2; bus2.dithered_valid = 1'b1;
    end
    @(posedge clk); #1 bus2.dithered_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (obs2_q.size() != 21) begin n_err++; $display("FAIL flush_count got %0d want 21", obs2_q.size()); end
    if (obs2_q.size() == 21) begin
      n_cmp++;
      if (obs2_q[0].d !== 16'hFFFF || obs2_q[0].a !== 13'd42) begin
        n_err++; $display("FAIL flush_first got %h@%0d want ffff@42", obs2_q[0].d, obs2_q[0].a);
      end
      n_cmp++;
      if (obs2_q[20].d !== 16'h00FF || obs2_q[20].a !== 13'd62) begin
        n_err++; $display("FAIL flush_last got %h@%0d want 00ff@62", obs2_q[20].d, obs2_q[20].a);
      end
    end
    obs2_q.delete();
  endtask

  task automatic test_out_of_range();
    px(1'b1, 5, 240);
    px(1'b1, 400, 0);
    px(1'b1, 15, 3, 1'b0);
    px(1'b1, 319, 240);
    px(1'b1, 15, 7, 1'b0);
    idle(3);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL oor_words got %0d want 0", obs_q.size()); end
    n_cmp++; if (bus.word_valid !== 1'b0) begin n_err++; $display("FAIL oor_valid got %b want 0", bus.word_valid); end
    px(1'b1, 3, 5);
    px(1'b0, 15, 5);
    idle(3);
    n_cmp++; if (obs_q.size() != 1) begin n_err++; $display("FAIL oor_follow_count got %0d want 1", obs_q.size()); end
    else begin
      n_cmp++;
      if (obs_q[0].d !== 16'h0008 || obs_q[0].a !== 13'd100) begin
        n_err++; $display("FAIL oor_follow_word got %h@%0d want 0008@100", obs_q[0].d, obs_q[0].a);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    ent_t o, e;
    logic p;
    bus.word_ready = 1'b0;
    for (int h = 0; h < 96; h++) begin
      p = 1'($urandom);
      px(p, h, 1);
      if (h == 64) begin
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_after4 got %b want 0", bus.overflow); end
      end
      if (h == 80) begin
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_after5 got %b want 1", bus.overflow); end
        n_cmp++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== exp_q[0].d) begin
          n_err++; $display("FAIL ovf_head got v%b %h want v1 %h", bus.word_valid, bus.word_data, exp_q[0].d);
        end
      end
    end
    idle(2);
    n_cmp++;
    if (bus.word_data !== exp_q[0].d || bus.word_addr !== 13'd20) begin
      n_err++; $display("FAIL ovf_head_hold got %h@%0d want %h@20", bus.word_data, bus.word_addr, exp_q[0].d);
    end
    void'(exp_q.pop_back()); void'(exp_q.pop_back());
    bus.word_ready = 1'b1;
    idle(8);
    n_cmp++; if (obs_q.size() != 4) begin n_err++; $display("FAIL ovf_drain_count got %0d want 4", obs_q.size()); end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o.d !== e.d || o.a !== e.a) begin
        n_err++; $display("FAIL ovf_word%0d got %h@%0d want %h@%0d", i, o.d, o.a, e.d, e.a);
      end
    end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
  endtask

  task automatic test_reset_midword();
    bus.word_ready = 1'b0;
    for (int h = 0; h < 24; h++) px(1'b1, h, 4);
    do_reset();
    n_cmp++; if (bus.word_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", bus.word_valid); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow got %b want 0", bus.overflow); end
    bus.word_ready = 1'b1;
    px(1'b1, 0, 4);
    for (int h = 8; h < 16; h++) px(1'b1, h, 4);
    idle(3);
    n_cmp++; if (obs_q.size() != 1) begin n_err++; $display("FAIL rstmid_count got %0d want 1", obs_q.size()); end
    else begin
      n_cmp++;
      if (obs_q[0].d !== 16'hFF01 || obs_q[0].a !== 13'd80) begin
        n_err++; $display("FAIL rstmid_word got %h@%0d want ff01@80", obs_q[0].d, obs_q[0].a);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_pop_push();
    ent_t o, e;
    bus.word_ready = 1'b0;
    for (int h = 0; h < 80; h++) begin
      px(1'($urandom), h, 3);
      if (h == 79) bus.word_ready = 1'b1;
    end
    idle(1);
    bus.word_ready = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fullpp_overflow got %b want 0", bus.overflow); end
    n_cmp++;
    if (bus.word_valid !== 1'b1 || bus.word_data !== exp_q[1].d || bus.word_addr !== exp_q[1].a) begin
      n_err++; $display("FAIL fullpp_head got %h@%0d want %h@%0d", bus.word_data, bus.word_addr, exp_q[1].d, exp_q[1].a);
    end
    bus.word_ready = 1'b1;
    idle(8);
    n_cmp++; if (obs_q.size() != 5) begin n_err++; $display("FAIL fullpp_count got %0d want 5", obs_q.size()); end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o.d !== e.d || o.a !== e.a) begin
        n_err++; $display("FAIL fullpp_word%0d got %h@%0d want %h@%0d", i, o.d, o.a, e.d, e.a);
      end
    end
  endtask

  task automatic test_frame_done();
    ent_t o, e;
    bus.word_ready = 1'b1;
    for (int h = 300; h < 320; h++) begin
      px(1'(h >> 1), h, 239);
      if (bus.frame_done !== 1'b0) begin
        n_cmp++; n_err++; $display("FAIL fd_early got %b want 0 at h %0d", bus.frame_done, h);
      end
    end
    idle(1);
    n_cmp++; if (bus.frame_done !== 1'b1) begin n_err++; $display("FAIL fd_pulse got %b want 1", bus.frame_done); end
    idle(1);
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL fd_width got %b want 0", bus.frame_done); end
    idle(3);
    n_cmp++; if (obs_q.size() != 2) begin n_err++; $display("FAIL fd_count got %0d want 2", obs_q.size()); end
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++;
      if (o.d !== e.d || o.a !== e.a) begin
        n_err++; $display("FAIL fd_word%0d got %h@%0d want %h@%0d", i, o.d, o.a, e.d, e.a);
      end
    end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fd_overflow got %b want 0", bus.overflow); end
  endtask

  initial begin
    bus.dithered_pixel = 1'b0; bus.dithered_hcount = '0; bus.dithered_vcount = '0;
    bus.dithered_valid = 1'b0; bus.word_ready = 1'b1;
    bus2.dithered_pixel = 1'b0; bus2.dithered_hcount = '0; bus2.dithered_vcount = '0;
    bus2.dithered_valid = 1'b0; bus2.word_ready = 1'b1;
    test_reset();
    test_row_pattern();
    test_row_flush();
    test_out_of_range();
    test_overflow();
    test_reset_midword();
    test_full_pop_push();
    test_frame_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
